// File: rtl/snr_pkg.sv
// Shared types and constants for the linear-to-dB SNR converter.
package snr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StFrac,
    StScale,
    StDone
  } state_e;

  // Q-format widths: linear input is Q16.16, dB output and log2 are Q8.8, mantissa is Q1.31.
  localparam int unsigned LIN_W      = 32;
  localparam int unsigned LIN_FRAC_W = 16;
  localparam int unsigned DB_W       = 16;
  localparam int unsigned DB_FRAC_W  = 8;
  localparam int unsigned MANT_W     = 32;

  // 10*log10(2) in Q3.13; the product with a Q8.8 log2 is rescaled by 13 bits.
  localparam logic signed [31:0] LOG10_2_Q13   = 32'sd24660;
  localparam int unsigned        LOG10_2_SHIFT = 13;
  localparam logic signed [31:0] SCALE_RND     = 32'sd4096;

  localparam logic [DB_W-1:0] SNR_DB_MIN = 16'h8000;

endpackage

// File: rtl/lod32.sv
// Combinational 32-bit leading-one detector: index of the highest set bit plus a zero flag.
module lod32 (
  input  logic [31:0] in_i,
  output logic [4:0]  idx_o,
  output logic        zero_o
);

  always_comb begin
    idx_o  = 5'd0;
    zero_o = (in_i == 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (in_i[i]) begin
        idx_o = 5'(i);
      end
    end
  end

endmodule

// File: rtl/calculate_snr_db.sv
// Converts a Q16.16 linear SNR to Q8.8 dB via a bit-serial log2 and a 10*log10(2) scale.
// Define SNR_DB_ROUND_EN to round the final scale half up instead of truncating.
module calculate_snr_db
  import snr_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_snr_db,
  input  logic [LIN_W-1:0] snr_linear,
  output logic [DB_W-1:0]  snr_db,
  output logic             done_snr_db,
  output logic             invalid_snr
);

  state_e state_q, state_d;

  logic [LIN_W-1:0]     x_q, x_d;
  logic [MANT_W-1:0]    m_q, m_d;
  logic [7:0]           int_q, int_d;
  logic [DB_FRAC_W-1:0] frac_q, frac_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DB_W-1:0]      snr_q, snr_d;
  logic                 done_q, done_d;
  logic                 invalid_q, invalid_d;
  logic                 armed_q, armed_d;

  logic [4:0]  lead_idx;
  logic        lead_zero;

  lod32 u_lod (
    .in_i   (x_q),
    .idx_o  (lead_idx),
    .zero_o (lead_zero)
  );

  // One squaring step: Q1.31 * Q1.31 -> Q2.62, renormalised back into Q1.31.
  logic [63:0]       sq;
  logic              frac_bit;
  logic [MANT_W-1:0] m_sq;

  assign sq       = 64'(m_q) * 64'(m_q);
  assign frac_bit = sq[63];
  assign m_sq     = frac_bit ? sq[63:32] : sq[62:31];

  logic [DB_FRAC_W-1:0] frac_al;
  logic [DB_W-1:0]      log2_q88;
  logic signed [31:0]   log2_ext;
  logic signed [31:0]   prod;
  logic signed [31:0]   prod_adj;
  logic signed [31:0]   db_shift;

  always_comb begin
    frac_al  = frac_q << (DB_FRAC_W - FRAC_BITS);
    log2_q88 = {int_q, frac_al};
    log2_ext = {{16{log2_q88[15]}}, log2_q88};
    prod     = log2_ext * LOG10_2_Q13;
`ifdef SNR_DB_ROUND_EN
    prod_adj = prod + SCALE_RND;
`else
    prod_adj = prod;
`endif
    db_shift = prod_adj >>> LOG10_2_SHIFT;
  end

  logic unused_bits;
  assign unused_bits = ^{sq[30:0], db_shift[31:16]};

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    m_d       = m_q;
    int_d     = int_q;
    frac_d    = frac_q;
    cnt_d     = cnt_q;
    snr_d     = snr_q;
    done_d    = done_q;
    invalid_d = invalid_q;
    armed_d   = armed_q;

    // A start must be seen low once before it can launch a new conversion.
    if (!start_snr_db) begin
      armed_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_snr_db && armed_q) begin
          x_d     = snr_linear;
          armed_d = 1'b0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (lead_zero) begin
          snr_d     = SNR_DB_MIN;
          invalid_d = 1'b1;
          state_d   = StDone;
        end else begin
          int_d     = {3'b000, lead_idx} - 8'd16;
          m_d       = x_q << (5'd31 - lead_idx);
          frac_d    = '0;
          cnt_d     = '0;
          invalid_d = 1'b0;
          state_d   = StFrac;
        end
      end
      StFrac: begin
        m_d    = m_sq;
        frac_d = {frac_q[DB_FRAC_W-2:0], frac_bit};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(FRAC_BITS - 1)) begin
          state_d = StScale;
        end
      end
      StScale: begin
        snr_d   = db_shift[15:0];
        state_d = StDone;
      end
      StDone: begin
        // done rises one edge after entering DONE so the result is already stable.
        if (!done_q) begin
          done_d = 1'b1;
        end else if (!start_snr_db) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      x_q       <= '0;
      m_q       <= '0;
      int_q     <= '0;
      frac_q    <= '0;
      cnt_q     <= '0;
      snr_q     <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      m_q       <= m_d;
      int_q     <= int_d;
      frac_q    <= frac_d;
      cnt_q     <= cnt_d;
      snr_q     <= snr_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
      armed_q   <= armed_d;
    end
  end

  assign snr_db      = snr_q;
  assign done_snr_db = done_q;
  assign invalid_snr = invalid_q;

endmodule

// File: tb/tb_calculate_snr_db.sv
// Directed bench for calculate_snr_db with hand-computed dB results and latencies.
module tb_calculate_snr_db;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] snr_linear;
  logic [15:0] snr_db;
  logic        done_snr_db;
  logic        invalid_snr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  calculate_snr_db #(
    .FRAC_BITS (8)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start_snr_db (start),
    .snr_linear   (snr_linear),
    .snr_db       (snr_db),
    .done_snr_db  (done_snr_db),
    .invalid_snr  (invalid_snr)
  );

`ifdef SNR_DB_ROUND_EN
  localparam logic [15:0] ExpTen = 16'h09FF;
  localparam logic [15:0] ExpTwo = 16'h0303;
  localparam logic [15:0] ExpMax = 16'h3027;
`else
  localparam logic [15:0] ExpTen = 16'h09FE;
  localparam logic [15:0] ExpTwo = 16'h0302;
  localparam logic [15:0] ExpMax = 16'h3026;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one conversion, measure edges from the sampling edge to done, then handshake out.
  task automatic run_vec(input logic [31:0] x, input logic [15:0] exp_db, input logic exp_inv,
                         input int exp_lat, input bit disturb, input string tag);
    int lat;
    @(negedge clk);
    snr_linear = x;
    start      = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (disturb && n == 3) begin
        snr_linear = 32'h1234_5678;
        start      = 1'b0;
      end
      if (disturb && n == 5) start = 1'b1;
      if (done_snr_db) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_snr_db"}, {16'h0, snr_db}, {16'h0, exp_db});
    chk({tag, "_invalid"}, {31'h0, invalid_snr}, {31'h0, exp_inv});
    repeat (3) @(negedge clk);
    chk({tag, "_hold_done"}, {31'h0, done_snr_db}, 32'h1);
    chk({tag, "_hold_db"}, {16'h0, snr_db}, {16'h0, exp_db});
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_clr"}, {31'h0, done_snr_db}, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    snr_linear = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_done", {31'h0, done_snr_db}, 32'h0);
    chk("rst_snr_db", {16'h0, snr_db}, 32'h0);
    chk("rst_invalid", {31'h0, invalid_snr}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec(32'h0001_0000, 16'h0000, 1'b0, 11, 1'b0, "one");
    run_vec(32'h000A_0000, ExpTen, 1'b0, 11, 1'b0, "ten");
    run_vec(32'h0064_0000, 16'h13FD, 1'b0, 11, 1'b0, "hundred");
    run_vec(32'h0000_8000, 16'hFCFD, 1'b0, 11, 1'b0, "half");
    run_vec(32'h0002_0000, ExpTwo, 1'b0, 11, 1'b0, "two");
    run_vec(32'hFFFF_FFFF, ExpMax, 1'b0, 11, 1'b0, "max");
    run_vec(32'h0000_0001, 16'hCFD6, 1'b0, 11, 1'b0, "min");
    run_vec(32'h0064_0000, 16'h13FD, 1'b0, 11, 1'b1, "disturb");
    run_vec(32'h0000_0000, 16'h8000, 1'b1, 2, 1'b0, "zero");

    // Abort mid-FRAC: snr_db still shows 0x8000 from the zero run until reset clears it.
    @(negedge clk);
    snr_linear = 32'h000A_0000;
    start      = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("abort_done", {31'h0, done_snr_db}, 32'h0);
    chk("abort_snr_db", {16'h0, snr_db}, 32'h0);
    chk("abort_invalid", {31'h0, invalid_snr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("abort_stays_idle", {31'h0, done_snr_db}, 32'h0);
    chk("abort_db_idle", {16'h0, snr_db}, 32'h0);

    run_vec(32'h0064_0000, 16'h13FD, 1'b0, 11, 1'b0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
